// File: rtl/mips_regfile_wb.sv
// MIPS GPR file: one write-back port decoded onto 31 stored registers ($zero is hardwired),
// two combinational read ports with optional same-cycle write forwarding, and a commit counter.

module mips_regfile_wb_cell #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] val_q, val_d;

    always_comb val_d = ld_i ? d_i : val_q;

    always_ff @(posedge clk) begin
        if (!rst_n) val_q <= RST_VAL;
        else        val_q <= val_d;
    end

    assign q_o = val_q;
endmodule

module mips_regfile_wb #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] SP_INIT = 32'h0000_3FFC,
    parameter logic [WIDTH-1:0] GP_INIT = 32'h0000_1800,
    parameter bit               BYPASS  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [4:0]       waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [4:0]       raddr1,
    input  logic [4:0]       raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2,
    output logic [15:0]      wr_count
);
    logic [WIDTH-1:0] regs [32];
    logic [31:1]      ld;
    logic [15:0]      wr_count_q, wr_count_d;
    logic [4:0]       ra [2];
    logic [WIDTH-1:0] rd [2];

    assign regs[0] = '0;

    // Index 0 has no cell, so a write to $zero decodes to nothing and never counts.
    for (genvar i = 1; i < 32; i++) begin : g_reg
        localparam logic [WIDTH-1:0] RV = (i == 29) ? SP_INIT :
                                          (i == 28) ? GP_INIT : '0;
        assign ld[i] = we && (waddr == 5'(i));
        mips_regfile_wb_cell #(.WIDTH(WIDTH), .RST_VAL(RV)) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .ld_i  (ld[i]),
            .d_i   (wdata),
            .q_o   (regs[i])
        );
    end

    always_comb begin
        wr_count_d = wr_count_q;
        if (|ld) wr_count_d = wr_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) wr_count_q <= '0;
        else        wr_count_q <= wr_count_d;
    end

    assign ra[0] = raddr1;
    assign ra[1] = raddr2;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        always_comb begin
            rd[p] = regs[ra[p]];
            if (ra[p] == 5'd0)
                rd[p] = '0;
            else if (BYPASS && we && (waddr == ra[p]))
                rd[p] = wdata;
        end
    end

    assign rdata1   = rd[0];
    assign rdata2   = rd[1];
    assign wr_count = wr_count_q;
endmodule

// File: tb/tb_mips_regfile_wb.sv
// Bench for mips_regfile_wb: a forwarding and a non-forwarding instance share stimulus and
// are compared every cycle against an array-based model, plus fixed literal expectations.

module tb_mips_regfile_wb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr, raddr1, raddr2;
    logic [31:0] wdata;
    logic [31:0] r1b, r2b, r1n, r2n;
    logic [15:0] cntb, cntn;

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [32];
    logic [15:0] mcnt;
    bit          mvalid = 1'b0;

    always #5 clk = ~clk;

    mips_regfile_wb #(.BYPASS(1'b1)) u_byp (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(r1b), .rdata2(r2b), .wr_count(cntb)
    );

    mips_regfile_wb #(.BYPASS(1'b0)) u_nob (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(r1n), .rdata2(r2n), .wr_count(cntn)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural state: 32 words, $zero pinned, reset wins over a write.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 32; k++) mdl[k] <= 32'd0;
            mdl[28] <= 32'h0000_1800;
            mdl[29] <= 32'h0000_3FFC;
            mcnt    <= 16'd0;
            mvalid  <= 1'b1;
        end else if (we && waddr != 5'd0) begin
            mdl[waddr] <= wdata;
            mcnt       <= mcnt + 16'd1;
        end
    end

    function automatic logic [31:0] mexp(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && we && waddr == a) return wdata;
        return mdl[a];
    endfunction

    always @(negedge clk) begin
        if (mvalid) begin
            chk("byp_rd1", r1b, mexp(raddr1, 1'b1));
            chk("byp_rd2", r2b, mexp(raddr2, 1'b1));
            chk("nob_rd1", r1n, mexp(raddr1, 1'b0));
            chk("nob_rd2", r2n, mexp(raddr2, 1'b0));
            chk("byp_cnt", {16'd0, cntb}, {16'd0, mcnt});
            chk("nob_cnt", {16'd0, cntn}, {16'd0, mcnt});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b1; waddr = 5'd29; wdata = 32'hFFFF_FFFF;
        raddr1 = 5'd0; raddr2 = 5'd0;
        cyc(); cyc();
        rst_n = 1'b1; we = 1'b0;

        // reset contents on every address, both ports
        for (int a = 0; a < 32; a++) begin
            logic [31:0] e1, e2;
            raddr1 = 5'(a); raddr2 = 5'(31 - a);
            e1 = (a == 28) ? 32'h0000_1800 : (a == 29) ? 32'h0000_3FFC : 32'd0;
            e2 = (31 - a == 28) ? 32'h0000_1800 : (31 - a == 29) ? 32'h0000_3FFC : 32'd0;
            @(negedge clk);
            chk("rst_lit1", r1b, e1);
            chk("rst_lit2", r2n, e2);
            cyc();
        end
        chk("rst_cnt", {16'd0, cntb}, 32'd0);

        we = 1'b1; waddr = 5'd5;  wdata = 32'hDEAD_BEEF; cyc();
        waddr = 5'd31; wdata = 32'h1234_5678; cyc();
        we = 1'b0; raddr1 = 5'd5; raddr2 = 5'd31;
        @(negedge clk);
        chk("wr_r5",  r1n, 32'hDEAD_BEEF);
        chk("wr_r31", r2n, 32'h1234_5678);
        chk("wr_cnt", {16'd0, cntn}, 32'd2);
        raddr1 = 5'd4; raddr2 = 5'd6; #1;
        chk("hold_r4", r1b, 32'd0);
        chk("hold_r6", r2b, 32'd0);
        cyc();

        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr1 = 5'd0; cyc();
        we = 1'b0;
        @(negedge clk);
        chk("zero_rd",  r1b, 32'd0);
        chk("zero_cnt", {16'd0, cntb}, 32'd2);
        cyc();

        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_A5A5; raddr1 = 5'd7; raddr2 = 5'd7;
        @(negedge clk);
        chk("fwd_b1", r1b, 32'hA5A5_A5A5);
        chk("fwd_b2", r2b, 32'hA5A5_A5A5);
        chk("old_n1", r1n, 32'd0);
        chk("old_n2", r2n, 32'd0);
        cyc();
        we = 1'b0;
        @(negedge clk);
        chk("new_n1", r1n, 32'hA5A5_A5A5);
        chk("new_n2", r2n, 32'hA5A5_A5A5);
        cyc();

        // random traffic with read/write address collisions and sporadic resets
        for (int n = 0; n < 3000; n++) begin
            rst_n  = ($urandom_range(63) != 0);
            we     = $urandom_range(1);
            waddr  = 5'($urandom_range(31));
            wdata  = $urandom;
            raddr1 = ($urandom_range(2) == 0) ? waddr : 5'($urandom_range(31));
            raddr2 = ($urandom_range(2) == 0) ? raddr1 : 5'($urandom_range(31));
            cyc();
        end

        rst_n = 1'b0; we = 1'b1; waddr = 5'd29; wdata = 32'd0; raddr1 = 5'd29; raddr2 = 5'd28;
        cyc();
        rst_n = 1'b1; we = 1'b0;
        @(negedge clk);
        chk("coll_sp",  r1b, 32'h0000_3FFC);
        chk("coll_gp",  r2n, 32'h0000_1800);
        chk("coll_cnt", {16'd0, cntb}, 32'd0);
        cyc();

        raddr1 = 5'd3; raddr2 = 5'd3;
        for (int i = 0; i < 65536; i++) begin
            we = 1'b1; waddr = 5'd3; wdata = 32'(i);
            if (i == 65535) begin
                @(negedge clk);
                chk("wrap_ffff", {16'd0, cntn}, 32'h0000_FFFF);
            end
            cyc();
        end
        we = 1'b0;
        @(negedge clk);
        chk("wrap_cnt", {16'd0, cntb}, 32'd0);
        chk("wrap_r3",  r1n, 32'h0000_FFFF);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_regfile_wb.md
Name: mips_regfile_wb

Overview:
- Register file for the MIPS CPU: the distributing counterpart of the operand-select muxes.
- One write-back port decodes a 5-bit destination address into a write enable for one of 32 GPRs.
- Two read ports return register values to the decode stage.
- Includes write-to-read bypass so that a same-cycle read of the register being written returns the new value.

Parameters:
- WIDTH, 32, data width of each register.
- SP_INIT, 32'h0000_3FFC, reset value of register 29 ($sp).
- GP_INIT, 32'h0000_1800, reset value of register 28 ($gp).
- BYPASS, 1, 1 = read ports forward same-cycle write data; 0 = read ports return stored contents only.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- we  input  1  write enable for the write-back port.
- waddr  input  5  destination register number.
- wdata  input  WIDTH  write-back data.
- raddr1  input  5  read port 1 address (rs).
- raddr2  input  5  read port 2 address (rt).
- rdata1  output  WIDTH  read port 1 data.
- rdata2  output  WIDTH  read port 2 data.
- wr_count  output  16  count of committed writes since reset; wraps.

Behaviour:
- Storage: 32 x WIDTH registers.
  - Register 0 is not stored; it always reads 0 and ignores writes.
- Reset (rst_n=0 at posedge clk):
  - All registers clear to 0, except reg 28 = GP_INIT and reg 29 = SP_INIT.
  - wr_count = 0.
  - Reset takes priority over a simultaneous write; the write is discarded.
- After reset, with no writes, rdata1/rdata2 follow the reset contents.
- Write decode: at posedge clk with rst_n=1, we=1 and waddr!=0:
  - Only reg[waddr] loads wdata.
  - All other registers hold.
  - wr_count increments by 1; 16'hFFFF wraps to 0.
- we=1 with waddr=0: no register changes and wr_count does not increment.
- we=0: no state changes.
- Read, combinational (zero-cycle latency):
  - rdataN = 0 if raddrN == 0.
  - Otherwise, if BYPASS=1 and we=1 and waddr == raddrN, rdataN = wdata.
  - Otherwise rdataN = reg[raddrN].
- BYPASS=0: a same-cycle read returns the old value; the new value is visible after the clock edge.
- Both read ports may address the same register, including the register being written; both return identical data.
- rdata1 and rdata2 have no X or unknown states after the first reset; contents before the first reset are undefined.
- Reset mid-stream: a write presented in the reset cycle is lost, and the next cycle reads the reset values.

Test Plan:
- Reset, then read all 32 addresses on both ports -> 0 everywhere except reg28=32'h0000_1800 and reg29=32'h0000_3FFC; wr_count=0.
- Write reg5=32'hDEAD_BEEF, then reg31=32'h1234_5678; read raddr1=5, raddr2=31 -> 32'hDEAD_BEEF and 32'h1234_5678; wr_count=2; reg4 and reg6 unchanged at 0.
- Write reg0=32'hFFFF_FFFF with we=1, then read raddr1=0 -> 0; wr_count unchanged.
- BYPASS=1: we=1, waddr=7, wdata=32'hA5A5_A5A5, raddr1=raddr2=7 in the same cycle -> both rdata = 32'hA5A5_A5A5 before the edge.
- BYPASS=0, same stimulus -> both rdata equal the old value before the edge and 32'hA5A5_A5A5 after it.
- Reset collision and wrap:
  - Assert rst_n=0 with we=1, waddr=29, wdata=0 -> reg29 reads 32'h0000_3FFC next cycle.
  - Perform 65536 writes to reg3 -> wr_count returns to 0 and reg3 holds the last value written.
